traffic_light_xing: RTL and testbench

Parametrised two-road intersection controller: the successor to the single-road green/yellow/red sequencer. It drives north-south (NS) and east-west (EW) signal heads with configurable phase durations and an all-red clearance interval, serves latched pedestrian requests with a dedicated walk phase, and provides a flashing-yellow night mode. It runs on the system clock and advances only on a one-cycle 1 Hz tick enable from the existing seconds prescaler.

---
 rtl/traffic_light_xing.sv | 94 +++++++++
 tb/tb_traffic_light_xing.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_xing.sv
// traffic_light_xing: two-road intersection controller with all-red clearance, pedestrian walk and flashing night mode
module traffic_light_xing #(
  parameter int CNT_W = 6,
  parameter int G_T   = 20,
  parameter int Y_T   = 4,
  parameter int AR_T  = 2,
  parameter int PED_T = 10
) (
  input  logic             sys_clk,
  input  logic             sys_rst_p,
  input  logic             tick_1s,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic [2:0]       light_ns,
  output logic [2:0]       light_ew,
  output logic [CNT_W-1:0] light_t,
  output logic             ped_walk,
  output logic             ped_pending
);
  localparam int MAXV = (1 << CNT_W) - 1;
  if (G_T < 1 || G_T > MAXV || Y_T < 1 || Y_T > MAXV || AR_T < 1 || AR_T > MAXV || PED_T < 1 || PED_T > MAXV) begin : g_bad
    $error("traffic_light_xing: duration out of range 1..2^CNT_W-1");
  end
  typedef enum logic [2:0] {NS_G, NS_Y, AR, EW_G, EW_Y, PED, NIGHT} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt_n;
  logic nxt_dir, dir_n, flash, flash_n, pend_n;
  always_comb begin
    st_n = st;
    cnt_n = light_t;
    dir_n = nxt_dir;
    flash_n = flash;
    if (tick_1s) begin
      if (st == NIGHT) begin
        flash_n = ~flash;
        if (!night_mode) begin
          st_n = AR;
          cnt_n = CNT_W'(AR_T);
          dir_n = 1'b0;
        end
      end else if (light_t != CNT_W'(1)) begin
        cnt_n = light_t - CNT_W'(1);
      end else begin
        case (st)
          NS_G: begin
            st_n = NS_Y;
            cnt_n = CNT_W'(Y_T);
            dir_n = 1'b1;
          end
          EW_G: begin
            st_n = EW_Y;
            cnt_n = CNT_W'(Y_T);
            dir_n = 1'b0;
          end
          NS_Y, EW_Y: begin
            st_n = AR;
            cnt_n = CNT_W'(AR_T);
          end
          AR: begin
            st_n = night_mode ? NIGHT : ped_pending ? PED : nxt_dir ? EW_G : NS_G;
            cnt_n = night_mode ? '0 : ped_pending ? CNT_W'(PED_T) : CNT_W'(G_T);
            flash_n = 1'b1;
          end
          default: begin
            st_n = nxt_dir ? EW_G : NS_G;
            cnt_n = CNT_W'(G_T);
          end
        endcase
      end
    end
    pend_n = ((st_n == PED || st_n == NIGHT) && st_n != st) ? 1'b0
           : ped_pending | (ped_req && st != PED && st != NIGHT);
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      st <= AR;
      light_t <= CNT_W'(AR_T);
      nxt_dir <= 1'b0;
      flash <= 1'b0;
      ped_pending <= 1'b0;
    end else begin
      st <= st_n;
      light_t <= cnt_n;
      nxt_dir <= dir_n;
      flash <= flash_n;
      ped_pending <= pend_n;
    end
  end
  always_comb begin
    light_ns = (st == NS_G) ? 3'b001 : (st == NS_Y) ? 3'b010 : (st == NIGHT) ? {1'b0, flash, 1'b0} : 3'b100;
    light_ew = (st == EW_G) ? 3'b001 : (st == EW_Y) ? 3'b010 : (st == NIGHT) ? {1'b0, flash, 1'b0} : 3'b100;
    ped_walk = (st == PED);
  end
endmodule

// File: tb/tb_traffic_light_xing.sv
// tb_traffic_light_xing: directed stimulus against a phase-table model plus literal checkpoints
module tb_traffic_light_xing;
  logic sys_clk = 0, sys_rst_p = 1, tick_1s = 0, ped_req = 0, night_mode = 0, tick2 = 0;
  logic [2:0] light_ns, light_ew, ns2, ew2;
  logic [5:0] light_t;
  logic [2:0] t2;
  logic ped_walk, ped_pending, walk2, pend2;
  int n_cmp = 0, n_bad = 0;
  bit valid = 0;
  // model: phase index 0 NS_G,1 NS_Y,2 AR,3 EW_G,4 EW_Y,5 PED,6 NIGHT
  int m_ph = 2, m_el = 0;
  bit m_ew = 0, m_pend = 0, m_on = 0;

  traffic_light_xing dut (
    .sys_clk(sys_clk), .sys_rst_p(sys_rst_p), .tick_1s(tick_1s), .ped_req(ped_req),
    .night_mode(night_mode), .light_ns(light_ns), .light_ew(light_ew), .light_t(light_t),
    .ped_walk(ped_walk), .ped_pending(ped_pending));

  traffic_light_xing #(.CNT_W(3), .G_T(1), .Y_T(2), .AR_T(1), .PED_T(3)) dut2 (
    .sys_clk(sys_clk), .sys_rst_p(sys_rst_p), .tick_1s(tick2), .ped_req(1'b0),
    .night_mode(1'b0), .light_ns(ns2), .light_ew(ew2), .light_t(t2),
    .ped_walk(walk2), .ped_pending(pend2));

  always #5 sys_clk = ~sys_clk;

  function automatic int dur(int ph);
    return ph == 0 || ph == 3 ? 20 : ph == 1 || ph == 4 ? 4 : ph == 2 ? 2 : ph == 5 ? 10 : 0;
  endfunction

  function automatic int head(int ph, bit on, bit ns);
    if (ph == 6) return on ? 2 : 0;
    if (ph == (ns ? 0 : 3)) return 1;
    if (ph == (ns ? 1 : 4)) return 2;
    return 4;
  endfunction

  task automatic chk(string nm, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic mstep(bit tk, bit rq, bit nt, bit rs);
    int np;
    if (rs) begin
      m_ph = 2; m_el = 0; m_ew = 0; m_pend = 0; m_on = 0;
      return;
    end
    np = m_ph;
    if (tk && m_ph == 6) begin
      if (nt) m_on = !m_on;
      else begin np = 2; m_el = 0; m_ew = 0; end
    end else if (tk) begin
      m_el++;
      if (m_el == dur(m_ph)) begin
        m_el = 0;
        case (m_ph)
          0: begin np = 1; m_ew = 1; end
          3: begin np = 4; m_ew = 0; end
          1, 4: np = 2;
          2: begin
            np = nt ? 6 : m_pend ? 5 : (m_ew ? 3 : 0);
            m_on = 1;
          end
          default: np = m_ew ? 3 : 0;
        endcase
      end
    end
    if (np != m_ph && (np == 5 || np == 6)) m_pend = 0;
    else if (rq && m_ph != 5 && m_ph != 6) m_pend = 1;
    m_ph = np;
  endtask

  task automatic cyc(bit tk, bit rq, bit nt, bit rs);
    @(negedge sys_clk);
    tick_1s = tk; ped_req = rq; night_mode = nt; sys_rst_p = rs;
    @(posedge sys_clk);
    #1;
    mstep(tk, rq, nt, rs);
  endtask

  task automatic run(int n, bit rq, bit nt);
    for (int i = 0; i < n; i++) begin
      if (i % 3 == 1) cyc(0, rq, nt, 0);
      cyc(1, rq, nt, 0);
    end
  endtask

  always @(negedge sys_clk) begin
    if (valid) begin
      chk("ns", light_ns, head(m_ph, m_on, 1));
      chk("ew", light_ew, head(m_ph, m_on, 0));
      chk("t", light_t, m_ph == 6 ? 0 : dur(m_ph) - m_el);
      chk("walk", ped_walk, m_ph == 5);
      chk("pend", ped_pending, m_pend);
    end
  end

  initial begin
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    valid = 1;
    chk("rst_ns", light_ns, 4); chk("rst_ew", light_ew, 4); chk("rst_t", light_t, 2);
    chk("rst_walk", ped_walk, 0); chk("rst_pend", ped_pending, 0);
    chk("g1_rst_t", t2, 1);
    tick2 = 1; cyc(0, 0, 0, 0); tick2 = 0;
    chk("g1_ns", ns2, 1); chk("g1_t", t2, 1);
    tick2 = 1; cyc(0, 0, 0, 0); tick2 = 0;
    chk("g1_ns_y", ns2, 2); chk("g1_t_y", t2, 2);
    run(2, 0, 0);
    chk("nsg_ns", light_ns, 1); chk("nsg_t", light_t, 20);
    for (int i = 0; i < 1000; i++) cyc(0, 0, 0, 0);
    chk("idle_ns", light_ns, 1); chk("idle_t", light_t, 20);
    cyc(0, 1, 0, 0);
    chk("req_pend", ped_pending, 1);
    cyc(0, 0, 0, 0);
    run(20, 0, 0);
    chk("nsy_ns", light_ns, 2); chk("nsy_t", light_t, 4);
    run(4, 0, 0);
    chk("ar_ns", light_ns, 4); chk("ar_t", light_t, 2);
    run(2, 0, 0);
    chk("ped_walk", ped_walk, 1); chk("ped_t", light_t, 10); chk("ped_pend", ped_pending, 0);
    run(10, 1, 0);
    cyc(0, 0, 0, 0);
    chk("pedx_ew", light_ew, 1); chk("pedx_t", light_t, 20); chk("pedx_pend", ped_pending, 0);
    run(26, 0, 0);
    chk("ew2ns", light_ns, 1);
    run(26, 0, 0);
    chk("arx_ew", light_ew, 1); chk("arx_t", light_t, 20);
    run(26, 0, 1);
    chk("night_ns", light_ns, 2); chk("night_t", light_t, 0);
    run(1, 0, 1);
    chk("night_off", light_ew, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 1, 0);
    chk("night_pend", ped_pending, 0);
    run(1, 0, 1);
    chk("night_on", light_ns, 2);
    run(1, 0, 0);
    chk("nx_t", light_t, 2); chk("nx_ns", light_ns, 4);
    run(2, 0, 0);
    chk("nx_green", light_ns, 1);
    run(46, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst_pend", ped_pending, 1); chk("pre_rst_ew", light_ew, 2);
    cyc(1, 0, 0, 1);
    chk("mid_rst_t", light_t, 2); chk("mid_rst_ew", light_ew, 4); chk("mid_rst_pend", ped_pending, 0);
    cyc(0, 1, 0, 0);
    run(3, 0, 0);
    chk("rp_walk", ped_walk, 1);
    cyc(0, 0, 0, 1);
    chk("rp_walk_off", ped_walk, 0);
    cyc(0, 0, 0, 0);
    valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
